// File: rtl/apb_pkg.sv
`default_nettype none
// ============================================================================
// apb_pkg -- shared FSM encoding and defaults for the APB master arbiter
// Rev 1.0
// ============================================================================
package apb_pkg;

  localparam logic [2:0] STATE_IDLE   = 3'b001;
  localparam logic [2:0] STATE_SETUP  = 3'b010;
  localparam logic [2:0] STATE_ACCESS = 3'b100;

  typedef enum logic [2:0] {
    IDLE   = STATE_IDLE,
    SETUP  = STATE_SETUP,
    ACCESS = STATE_ACCESS
  } apb_state_e;

  localparam int         APB_TIMEOUT_DEFAULT = 16;
  localparam logic [2:0] APB_PPROT           = 3'b000;

endpackage
`default_nettype wire

// File: rtl/apb_rr_arb2.sv
`default_nettype none
// ============================================================================
// apb_rr_arb2 -- two-way round-robin arbiter, one-hot grant, priority moves on accept
// Rev 1.0
// ============================================================================
module apb_rr_arb2
  import apb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // 1 means requester 1 was served most recently, so requester 0 wins a tie
  logic last_q, last_d;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (accept && (grant != 2'b00)) begin
      last_d = grant[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_master_arb.sv
`default_nettype none
// ============================================================================
// apb_master_arb -- two requesters arbitrated onto one APB master port with timeout
// Rev 1.0
// ============================================================================
module apb_master_arb
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = APB_TIMEOUT_DEFAULT
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic [1:0]              req,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  output logic [1:0]              done,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [2:0]              PPROT,
  output logic                    PNSE,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  apb_state_e            state_q, state_d;
  logic                  sel_q, sel_d;
  logic                  write_q, write_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            done_q, done_d;
  logic                  err_q, err_d;
  logic [1:0]            arb_req;
  logic [1:0]            grant;

  // A requester still sees its done pulse this cycle and has not had a chance
  // to drop req yet, so it must not be re-granted on the same transfer.
  assign arb_req = req & ~done_q;

  apb_rr_arb2 u_arb (
    .clk    (PCLK),
    .rst_n  (PRESETn),
    .req    (arb_req),
    .accept (state_q == IDLE),
    .grant  (grant)
  );

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    done_d  = 2'b00;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          state_d = SETUP;
          sel_d   = grant[1];
          write_d = req_write[grant[1]];
          addr_d  = grant[1] ? req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : req_addr[ADDR_WIDTH-1:0];
          wdata_d = grant[1] ? req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : req_wdata[DATA_WIDTH-1:0];
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = '0;
      end
      ACCESS: begin
        // cnt_q counts completed wait cycles; the last allowed one forces an error end
        if (PREADY || (cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          done_d  = sel_q ? 2'b10 : 2'b01;
          err_d   = PREADY ? PSLVERR : 1'b1;
          if (PREADY && !write_q) begin
            rdata_d = PRDATA;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      done_q  <= 2'b00;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign PSEL      = (state_q == SETUP) || (state_q == ACCESS);
  assign PENABLE   = (state_q == ACCESS);
  assign PADDR     = addr_q;
  assign PWRITE    = write_q;
  assign PWDATA    = wdata_q;
  assign PPROT     = APB_PPROT;
  assign PNSE      = 1'b0;
  assign done      = done_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule
`default_nettype wire
